cp0_exc_unit: RTL and testbench
===============================

Name: cp0_exc_unit

Overview:
- Consumer end of the exception/eret fields that the EX/MEM pipeline register carries.
- Holds the CP0 architectural registers: BadVAddr, Count, Compare, Status, Cause and EPC.
- Commits exceptions and eret at the MEM stage, serves MFC0 reads, and executes MTC0 writes.
- Drives the pipeline-wide flush and the PC redirect, and raises an interrupt request to decode.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, general exception entry address.
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1, IE=0, EXL=0, IM=0).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  MEM stage held (dcache_stall); suppresses every commit and write
- MEM_Exception  in  1  exception tagged on the MEM instruction
- MEM_ExcCode  in  5  exception code
- MEM_isBD  in  1  MEM instruction sits in a delay slot
- MEM_PC  in  32  PC of the MEM instruction
- badvaddr  in  32  faulting address from EX/MEM
- MEM_eret_flush  in  1  MEM instruction is ERET
- MEM_CP0WrEn  in  1  MTC0 in MEM
- MEM_CP0Addr  in  8  {rd[4:0], sel[2:0]}
- wdata  in  32  MTC0 data (MEM_GPR_RT)
- hw_int  in  6  hardware interrupt lines, level-sensitive
- CP0Out  out  32  MFC0 read data, combinational on MEM_CP0Addr
- flush  out  1  flush all pipeline stages (PC_Flush/IF/ID/EX/MEM_Flush)
- redirect_pc  out  32  next-PC override, valid while flush=1
- int_req  out  1  pending enabled interrupt, to decode
- EPC_o  out  32  current EPC

Behaviour:
- Register addresses:
  - BadVAddr 8'h40
  - Count 8'h48
  - Compare 8'h58
  - Status 8'h60
  - Cause 8'h68
  - EPC 8'h70
  - Any other address reads 0; writes to it are ignored.
- Reset values:
  - Status=STATUS_RST; all other registers 0.
  - Internal count toggle tick=0.
  - Outputs: flush=0, int_req=0, CP0Out=0 for address 0.
- commit_exc = MEM_Exception & ~stall; commit_eret = MEM_eret_flush & ~MEM_Exception & ~stall.
- flush = commit_exc | commit_eret, combinational, same cycle. redirect_pc = commit_exc ? EXC_VECTOR : EPC.
- On commit_exc (next edge):
  - If Status.EXL==0: EPC <= MEM_isBD ? MEM_PC-4 : MEM_PC, and Cause.BD(31) <= MEM_isBD.
  - If Status.EXL==1: EPC and BD are unchanged.
  - Always: Status.EXL(1) <= 1 and Cause.ExcCode[6:2] <= MEM_ExcCode.
  - If MEM_ExcCode is AdEL(4) or AdES(5): BadVAddr <= badvaddr.
- On commit_eret: Status.EXL <= 0.
- MTC0 applies only when MEM_CP0WrEn & ~stall & ~MEM_Exception.
  - Status: writable bits IM[15:8], EXL[1], IE[0] only.
  - Cause: writable bits IP[9:8] only.
  - Count: full 32-bit write; also resets tick to 0.
  - Compare: full 32-bit write; clears Cause.TI(30).
  - EPC: full 32-bit write.
  - BadVAddr: read-only.
- Count and timer:
  - tick toggles every cycle; Count increments (wraps at 2^32) when tick=1, i.e. every 2 cycles.
  - A Count write in the same cycle takes precedence over the increment.
  - TI is set when Count==Compare and no Compare write occurs that cycle; it stays set until Compare is written.
  - When set and cleared coincide, the clear (Compare write) wins.
- Interrupt sampling:
  - Each cycle Cause.IP[15:10] <= {hw_int[5]|TI, hw_int[4:0]}.
- int_req = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]); registered-state based, no flop delay beyond the registers.
- Simultaneous events:
  - Exception beats eret beats MTC0.
  - With stall=1, nothing commits; Count and IP sampling continue.
- Reset mid-operation overrides everything and yields the reset values on the next edge.

Decomposition:
- Shared package (MacroDef): ExcCode constants (Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12), CP0 address constants, Status/Cause bit-position constants.
- Natural sub-module: cp0_timer (tick, Count, Compare, TI set/clear). Everything else stays in cp0_exc_unit.

Test Plan:
- Reset then read addr 8'h60 -> CP0Out=32'h0040_0000; read 8'h68 -> 0; flush=0.
- MEM_Exception=1, code 12 (Ov), PC=32'hBFC0_1004, isBD=0, EXL=0 -> flush=1 and redirect_pc=32'hBFC0_0380 that cycle; next cycle EPC=32'hBFC0_1004, Cause[6:2]=12, Status[1]=1, BadVAddr unchanged.
- AdEL, isBD=1, PC=32'h8000_0010, badvaddr=32'h8000_0123 -> EPC=32'h8000_000C, Cause[31]=1, BadVAddr=32'h8000_0123. A second exception while EXL=1 leaves EPC unchanged.
- After the exception, MEM_eret_flush=1 -> flush=1, redirect_pc=EPC, Status.EXL=0 next cycle. Same pulse with stall=1 -> flush=0 and no state change.
- MTC0 Compare=5, Count=0, Status=32'h0000_8001 -> Count reaches 5 after 10 cycles; TI=1, Cause[15]=1, int_req=1. MTC0 Compare -> TI=0, int_req=0.
- MTC0 Status with wdata=32'hFFFF_FFFF -> Status reads 32'h0040_FF03. MTC0 to 8'h40 -> BadVAddr unchanged. Simultaneous MEM_Exception and MTC0 -> write dropped.

Source files
------------

// File: rtl/cp0_exc_unit_pkg.sv
// rtl/cp0_exc_unit_pkg.sv - shared CP0 exception codes, register addresses and bit positions
package cp0_exc_unit_pkg;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_SYS  = 5'd8,
      EXC_BP   = 5'd9,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_t;

   typedef enum logic [7:0] {
      ADDR_BADVADDR = 8'h40,
      ADDR_COUNT    = 8'h48,
      ADDR_COMPARE  = 8'h58,
      ADDR_STATUS   = 8'h60,
      ADDR_CAUSE    = 8'h68,
      ADDR_EPC      = 8'h70
   } cp0_addr_t;

   localparam int ST_IE  = 0;
   localparam int ST_EXL = 1;

   // IM[15:8], EXL and IE are the only software-writable Status bits
   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == EXC_ADEL) || (code == EXC_ADES);
   endfunction

endpackage

// File: rtl/cp0_exc_unit_timer.sv
// rtl/cp0_exc_unit_timer.sv - Count/Compare timer, Count advances every second cycle
module cp0_exc_unit_timer
   import cp0_exc_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   logic tick;

   always_ff @(posedge clk) begin
      if (rst) begin
         tick    <= 1'b0;
         count   <= 32'd0;
         compare <= 32'd0;
         ti      <= 1'b0;
      end else begin
         if (count_we) begin
            count <= wdata;
            tick  <= 1'b0;
         end else begin
            tick <= ~tick;
            if (tick) count <= count + 32'd1;
         end
         // a Compare write acknowledges the timer interrupt and beats a same-cycle match
         if (compare_we) begin
            compare <= wdata;
            ti      <= 1'b0;
         end else if (count == compare) begin
            ti <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cp0_exc_unit.sv
// rtl/cp0_exc_unit.sv - CP0 registers, MEM-stage exception/eret commit, MFC0/MTC0, interrupt request
module cp0_exc_unit
   import cp0_exc_unit_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        MEM_Exception,
   input  logic [4:0]  MEM_ExcCode,
   input  logic        MEM_isBD,
   input  logic [31:0] MEM_PC,
   input  logic [31:0] badvaddr,
   input  logic        MEM_eret_flush,
   input  logic        MEM_CP0WrEn,
   input  logic [7:0]  MEM_CP0Addr,
   input  logic [31:0] wdata,
   input  logic [5:0]  hw_int,
   output logic [31:0] CP0Out,
   output logic        flush,
   output logic [31:0] redirect_pc,
   output logic        int_req,
   output logic [31:0] EPC_o
);

   logic        commit_exc, commit_eret, mtc0;
   logic [31:0] badvaddr_q, status, epc, count, compare, cause;
   logic        cause_bd, ti;
   logic [5:0]  cause_ip_hw;
   logic [1:0]  cause_ip_sw;
   logic [4:0]  cause_exc;

   assign commit_exc  = MEM_Exception & ~stall;
   assign commit_eret = MEM_eret_flush & ~MEM_Exception & ~stall;
   assign mtc0        = MEM_CP0WrEn & ~stall & ~MEM_Exception & ~MEM_eret_flush;

   assign flush       = commit_exc | commit_eret;
   assign redirect_pc = commit_exc ? EXC_VECTOR : epc;
   assign EPC_o       = epc;

   assign cause   = {cause_bd, ti, 14'd0, cause_ip_hw, cause_ip_sw, 1'b0, cause_exc, 2'b00};
   assign int_req = status[ST_IE] & ~status[ST_EXL] & (|({cause_ip_hw, cause_ip_sw} & status[15:8]));

   cp0_exc_unit_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .count_we   (mtc0 && (MEM_CP0Addr == ADDR_COUNT)),
      .compare_we (mtc0 && (MEM_CP0Addr == ADDR_COMPARE)),
      .wdata      (wdata),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

   always_comb begin
      CP0Out = 32'd0;
      case (MEM_CP0Addr)
         ADDR_BADVADDR: CP0Out = badvaddr_q;
         ADDR_COUNT:    CP0Out = count;
         ADDR_COMPARE:  CP0Out = compare;
         ADDR_STATUS:   CP0Out = status;
         ADDR_CAUSE:    CP0Out = cause;
         ADDR_EPC:      CP0Out = epc;
         default:       CP0Out = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         badvaddr_q  <= 32'd0;
         status      <= STATUS_RST;
         epc         <= 32'd0;
         cause_bd    <= 1'b0;
         cause_ip_hw <= 6'd0;
         cause_ip_sw <= 2'd0;
         cause_exc   <= 5'd0;
      end else begin
         // the timer interrupt shares IP7 with hw_int[5]
         cause_ip_hw <= {hw_int[5] | ti, hw_int[4:0]};
         if (commit_exc) begin
            // nested exceptions keep the EPC of the outermost one
            if (!status[ST_EXL]) begin
               epc      <= MEM_isBD ? (MEM_PC - 32'd4) : MEM_PC;
               cause_bd <= MEM_isBD;
            end
            status[ST_EXL] <= 1'b1;
            cause_exc      <= MEM_ExcCode;
            if (is_addr_exc(MEM_ExcCode)) badvaddr_q <= badvaddr;
         end else if (commit_eret) begin
            status[ST_EXL] <= 1'b0;
         end else if (mtc0) begin
            case (MEM_CP0Addr)
               ADDR_STATUS: status      <= (status & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
               ADDR_CAUSE:  cause_ip_sw <= wdata[9:8];
               ADDR_EPC:    epc         <= wdata;
               default:     ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb/tb_cp0_exc_unit.sv - scoreboard bench for cp0_exc_unit with a reference model of the CP0 rules
module tb_cp0_exc_unit;

   logic        clk = 1'b0;
   logic        rst, stall, MEM_Exception, MEM_isBD, MEM_eret_flush, MEM_CP0WrEn;
   logic [4:0]  MEM_ExcCode;
   logic [31:0] MEM_PC, badvaddr, wdata;
   logic [7:0]  MEM_CP0Addr;
   logic [5:0]  hw_int;
   logic [31:0] CP0Out, redirect_pc, EPC_o;
   logic        flush, int_req;

   cp0_exc_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .MEM_Exception(MEM_Exception), .MEM_ExcCode(MEM_ExcCode),
      .MEM_isBD(MEM_isBD), .MEM_PC(MEM_PC), .badvaddr(badvaddr), .MEM_eret_flush(MEM_eret_flush),
      .MEM_CP0WrEn(MEM_CP0WrEn), .MEM_CP0Addr(MEM_CP0Addr), .wdata(wdata), .hw_int(hw_int),
      .CP0Out(CP0Out), .flush(flush), .redirect_pc(redirect_pc), .int_req(int_req), .EPC_o(EPC_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit rst, stall, exc, isbd, eret, we;
      logic [4:0]  code;
      logic [31:0] pc, bad, wdata;
      logic [7:0]  addr;
      logic [5:0]  hw;
   } stim_t;

   typedef struct {
      bit          chk;
      logic        flush, irq;
      logic [31:0] rpc, cp0, epc;
   } exp_t;

   exp_t q[$];
   int   checks = 0, errors = 0;

   // reference state, one variable per architectural field
   logic [31:0] m_count, m_compare, m_status, m_epc, m_bad;
   logic        m_tick, m_ti, m_bd, m_valid = 1'b0;
   logic [4:0]  m_code;
   logic [5:0]  m_iphw;
   logic [1:0]  m_ipsw;

   function automatic logic [31:0] m_read(input logic [7:0] a);
      case (a)
         8'h40:   return m_bad;
         8'h48:   return m_count;
         8'h58:   return m_compare;
         8'h60:   return m_status;
         8'h68:   return {m_bd, m_ti, 14'd0, m_iphw, m_ipsw, 1'b0, m_code, 2'b00};
         8'h70:   return m_epc;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic m_irq();
      return m_status[0] && !m_status[1] && (({m_iphw, m_ipsw} & m_status[15:8]) != 8'd0);
   endfunction

   task automatic m_step(input stim_t s);
      bit ce, cr, mw;
      if (s.rst) begin
         m_count = 0; m_compare = 0; m_status = 32'h0040_0000; m_epc = 0; m_bad = 0;
         m_tick = 0; m_ti = 0; m_bd = 0; m_code = 0; m_iphw = 0; m_ipsw = 0; m_valid = 1;
         return;
      end
      ce = s.exc && !s.stall;
      cr = s.eret && !s.exc && !s.stall;
      mw = s.we && !s.stall && !s.exc && !s.eret;
      m_iphw = {s.hw[5] | m_ti, s.hw[4:0]};
      if (mw && s.addr == 8'h58) m_ti = 0;
      else if (m_count == m_compare) m_ti = 1;
      if (mw && s.addr == 8'h58) m_compare = s.wdata;
      if (mw && s.addr == 8'h48) begin
         m_count = s.wdata; m_tick = 0;
      end else begin
         if (m_tick) m_count = m_count + 1;
         m_tick = !m_tick;
      end
      if (ce) begin
         if (!m_status[1]) begin
            m_epc = s.isbd ? s.pc - 4 : s.pc;
            m_bd  = s.isbd;
         end
         m_status[1] = 1;
         m_code = s.code;
         if (s.code == 5'd4 || s.code == 5'd5) m_bad = s.bad;
      end else if (cr) begin
         m_status[1] = 0;
      end else if (mw) begin
         if (s.addr == 8'h60) m_status = (m_status & ~32'h0000_FF03) | (s.wdata & 32'h0000_FF03);
         if (s.addr == 8'h68) m_ipsw = s.wdata[9:8];
         if (s.addr == 8'h70) m_epc = s.wdata;
      end
   endtask

   function automatic stim_t idle(input logic [7:0] addr);
      stim_t s;
      s = '{rst: 0, stall: 0, exc: 0, isbd: 0, eret: 0, we: 0, code: 0, pc: 0, bad: 0, wdata: 0, addr: addr, hw: 0};
      return s;
   endfunction

   task automatic cyc(input stim_t s, input bit use_c = 0, input logic [31:0] cval = 0);
      exp_t e;
      bit   ce;
      @(posedge clk); #2;
      rst = s.rst; stall = s.stall; MEM_Exception = s.exc; MEM_ExcCode = s.code; MEM_isBD = s.isbd;
      MEM_PC = s.pc; badvaddr = s.bad; MEM_eret_flush = s.eret; MEM_CP0WrEn = s.we;
      MEM_CP0Addr = s.addr; wdata = s.wdata; hw_int = s.hw;
      ce      = s.exc && !s.stall;
      e.chk   = m_valid;
      e.flush = ce || (s.eret && !s.stall);
      e.rpc   = ce ? 32'hBFC0_0380 : m_epc;
      e.cp0   = use_c ? cval : m_read(s.addr);
      e.irq   = m_irq();
      e.epc   = m_epc;
      q.push_back(e);
      m_step(s);
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] v);
      cyc(idle(a), 1, v);
   endtask

   task automatic exc(input logic [4:0] code, input logic [31:0] pc, input bit bd, input logic [31:0] bad);
      stim_t s;
      s = idle(8'h00); s.exc = 1; s.code = code; s.pc = pc; s.isbd = bd; s.bad = bad;
      cyc(s);
   endtask

   task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
      stim_t s;
      s = idle(a); s.we = 1; s.wdata = d;
      cyc(s);
   endtask

   task automatic eret(input bit stl);
      stim_t s;
      s = idle(8'h60); s.eret = 1; s.stall = stl;
      cyc(s);
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk) begin
               cmp("flush", {31'd0, flush}, {31'd0, e.flush});
               if (e.flush) cmp("redirect_pc", redirect_pc, e.rpc);
               cmp("CP0Out", CP0Out, e.cp0);
               cmp("int_req", {31'd0, int_req}, {31'd0, e.irq});
               cmp("EPC_o", EPC_o, e.epc);
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin : driver
      stim_t s;
      logic [4:0] codes [7] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
      logic [7:0] addrs [7] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h00};
      logic [5:0] hw = 0;
      s = idle(8'h00); s.rst = 1;
      cyc(s); cyc(s);
      rd(8'h68, 32'h0);
      rd(8'h60, 32'h0040_0000);
      exc(5'd12, 32'hBFC0_1004, 0, 32'h1111_1111);
      rd(8'h70, 32'hBFC0_1004);
      rd(8'h60, 32'h0040_0002);
      rd(8'h40, 32'h0);
      cyc(idle(8'h68));
      eret(0);
      rd(8'h60, 32'h0040_0000);
      exc(5'd4, 32'h8000_0010, 1, 32'h8000_0123);
      rd(8'h70, 32'h8000_000C);
      rd(8'h40, 32'h8000_0123);
      exc(5'd8, 32'h1234_5678, 0, 32'h0);
      rd(8'h70, 32'h8000_000C);
      cyc(idle(8'h68));
      eret(1);
      rd(8'h60, 32'h0040_0002);
      eret(0);
      mtc0(8'h58, 32'd5);
      mtc0(8'h60, 32'h0000_8001);
      mtc0(8'h48, 32'd0);
      repeat (14) cyc(idle(8'h48));
      rd(8'h48, 32'd7);
      cyc(idle(8'h68));
      mtc0(8'h58, 32'd1000);
      repeat (3) cyc(idle(8'h68));
      mtc0(8'h60, 32'hFFFF_FFFF);
      rd(8'h60, 32'h0040_FF03);
      mtc0(8'h60, 32'h0);
      mtc0(8'h40, 32'hFFFF_FFFF);
      rd(8'h40, 32'h8000_0123);
      s = idle(8'h70); s.exc = 1; s.code = 5'd9; s.pc = 32'h0000_1000; s.we = 1; s.wdata = 32'hDEAD_BEEF;
      cyc(s);
      rd(8'h70, 32'h0000_1000);
      eret(0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(15) == 0) hw = 6'($urandom);
         s = idle(addrs[$urandom_range(6)]);
         if (s.addr == 8'h00) s.addr = 8'($urandom);
         s.rst   = ($urandom_range(199) == 0);
         s.stall = ($urandom_range(3) == 0);
         s.exc   = ($urandom_range(7) == 0);
         s.eret  = ($urandom_range(7) == 0);
         s.we    = !s.eret && ($urandom_range(3) == 0);
         s.code  = codes[$urandom_range(6)];
         s.isbd  = 1'($urandom);
         s.pc    = $urandom & 32'hFFFF_FFFC;
         s.bad   = $urandom;
         s.wdata = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom;
         s.hw    = hw;
         cyc(s);
      end
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
